grf_scoreboard: RTL and testbench
=================================

GRF_SCOREBOARD -- requirements
Module: grf_scoreboard

Interface
REQ-001 Parameter DW, default 32, data width of each register.
REQ-002 Parameter AW, default 5, address width; depth is 2**AW registers.
REQ-003 Parameter NR, default 2, number of read ports (1..4).
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 rd_addr  input  NR*AW  read addresses; port k uses bits [k*AW +: AW].
REQ-007 rd_data  output  NR*DW  read data; port k uses bits [k*DW +: DW].
REQ-008 rd_busy  output  NR  per-port flag: a result is still outstanding for rd_addr[k].
REQ-009 we  input  1  write (writeback) enable.
REQ-010 wa  input  AW  write address.
REQ-011 wd  input  DW  write data.
REQ-012 wpc  input  32  PC of the instruction performing the write (trace only).
REQ-013 iss_en  input  1  issue strobe: mark iss_addr as pending.
REQ-014 iss_addr  input  AW  destination register of the issued instruction.
REQ-015 busy_cnt  output  AW+1  number of registers currently pending.
REQ-016 trace_valid  output  1  registered strobe: a write to a nonzero register committed last cycle.
REQ-017 trace_pc, trace_addr, trace_data  output  32, AW, DW  PC, address and data of that committed write.

Function
REQ-018 Storage SHALL be 2**AW registers of DW bits; register 0 SHALL always read 0, and writes and issues to address 0 SHALL be ignored.
REQ-019 Write: on a rising edge with we=1, reset=0, wa!=0, reg[wa] SHALL take wd.
REQ-020 Read: each port SHALL be combinational; rd_data[k] = wd when we=1, wa=rd_addr[k]!=0 (same-cycle bypass), else reg[rd_addr[k]].
REQ-021 Scoreboard: one busy bit per register, all 0 after reset; bit 0 SHALL be constant 0.
REQ-022 On an edge with iss_en=1, iss_addr!=0, busy[iss_addr] SHALL become 1.
REQ-023 On an edge with we=1, wa!=0, busy[wa] SHALL become 0 unless REQ-022 sets the same bit in that edge.
REQ-024 Simultaneous issue and writeback to the same address SHALL leave busy=1 (the new producer wins).
REQ-025 Issue to an already-busy register SHALL leave it busy with busy_cnt unchanged; writeback to a non-busy register SHALL write data and leave busy_cnt unchanged.
REQ-026 rd_busy[k] SHALL be busy[rd_addr[k]] AND NOT (we=1 AND wa=rd_addr[k]); when bypass data is returned, rd_busy[k] SHALL be 0.
REQ-027 busy_cnt SHALL equal the population count of the busy bits; it SHALL be maintained as a registered counter (+1 on a new set, -1 on a clear, net 0 when both apply to different addresses in one edge) and SHALL never wrap.
REQ-028 Trace: on the edge after a committed write (REQ-019), trace_valid SHALL be 1 for one cycle with trace_pc=wpc, trace_addr=wa, trace_data=wd; otherwise trace_valid=0 and the other trace outputs hold their last value.
REQ-029 A write with wa=0 SHALL produce no trace.

Reset
REQ-030 While reset=1 at an edge: all registers 0, all busy bits 0, busy_cnt=0, trace_valid=0, trace_pc/addr/data=0.
REQ-031 Reset SHALL dominate we and iss_en in the same cycle; neither a write nor an issue SHALL take effect and no trace SHALL be emitted.
REQ-032 Reset asserted while registers are busy SHALL clear all pending state in one cycle.

Verification
REQ-033 Write wa=5, wd=0x1234_5678, wpc=0x3000 -> next cycle reg5 reads 0x12345678; trace_valid=1, trace_pc=0x3000, trace_addr=5, trace_data=0x12345678.
REQ-034 we=1, wa=0, wd=0xFFFF_FFFF; read port 0 at address 0 -> rd_data=0 in the same and the next cycle; trace_valid stays 0.
REQ-035 Issue to 3, 7, 3 on consecutive cycles -> busy_cnt 1, 2, 2; writeback to 3 -> busy_cnt 1, rd_busy for address 3 = 0, for address 7 = 1.
REQ-036 Same cycle: iss_en to 9 and we to 9 while 9 is busy -> reg9 updated, busy[9] stays 1, busy_cnt unchanged.
REQ-037 Same cycle: we=1, wa=4, wd=0xAA, port 1 reading 4 while busy -> rd_data[1]=0xAA and rd_busy[1]=0 in that cycle.
REQ-038 Issue to 1..4, then reset together with we=1, wa=2 -> next cycle busy_cnt=0, reg2=0, trace_valid=0.

Source files
------------

// File: rtl/grf_scoreboard.sv
// General register file with a per-register busy scoreboard, same-cycle
// writeback bypass on every read port, and a one-cycle commit trace.
module grf_scoreboard #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int NR = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NR*AW-1:0]   rd_addr,
    output logic [NR*DW-1:0]   rd_data,
    output logic [NR-1:0]      rd_busy,
    input  logic               we,
    input  logic [AW-1:0]      wa,
    input  logic [DW-1:0]      wd,
    input  logic [31:0]        wpc,
    input  logic               iss_en,
    input  logic [AW-1:0]      iss_addr,
    output logic [AW:0]        busy_cnt,
    output logic               trace_valid,
    output logic [31:0]        trace_pc,
    output logic [AW-1:0]      trace_addr,
    output logic [DW-1:0]      trace_data
);

    localparam int DEPTH = 2 ** AW;
    localparam int CW    = AW + 1;

    logic [DW-1:0]    regs [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;
    logic [AW:0]      cnt_nxt;
    logic             wr_commit;
    logic             iss_set;
    logic             cnt_inc;
    logic             cnt_dec;

    assign wr_commit = we && (wa != '0);
    assign iss_set   = iss_en && (iss_addr != '0);

    // Read ports: bypass the in-flight writeback, never report it as busy.
    for (genvar k = 0; k < NR; k++) begin : g_rd
        logic [AW-1:0] addr;
        logic          wr_hit;

        assign addr   = rd_addr[k*AW +: AW];
        assign wr_hit = we && (wa == addr);

        always_comb begin
            if (addr == '0) begin
                rd_data[k*DW +: DW] = '0;
            end else if (wr_hit) begin
                rd_data[k*DW +: DW] = wd;
            end else begin
                rd_data[k*DW +: DW] = regs[addr];
            end
        end

        assign rd_busy[k] = busy[addr] && !wr_hit;
    end

    // Scoreboard update: issue is applied after writeback so a new producer wins.
    always_comb begin
        busy_nxt = busy;
        if (wr_commit) begin
            busy_nxt[wa] = 1'b0;
        end
        if (iss_set) begin
            busy_nxt[iss_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // Counter tracks edges of busy bits so it always equals their popcount.
    always_comb begin
        cnt_inc = iss_set && !busy[iss_addr];
        cnt_dec = wr_commit && busy[wa] && !(iss_set && (iss_addr == wa));
        cnt_nxt = busy_cnt + CW'(cnt_inc) - CW'(cnt_dec);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy        <= '0;
            busy_cnt    <= '0;
            trace_valid <= 1'b0;
            trace_pc    <= '0;
            trace_addr  <= '0;
            trace_data  <= '0;
        end else begin
            if (wr_commit) begin
                regs[wa]   <= wd;
                trace_pc   <= wpc;
                trace_addr <= wa;
                trace_data <= wd;
            end
            busy        <= busy_nxt;
            busy_cnt    <= cnt_nxt;
            trace_valid <= wr_commit;
        end
    end

endmodule

// File: tb/tb_grf_scoreboard.sv
// Directed scoreboard bench: stimulus queues per-cycle expectations and
// expected trace records; negedge monitors pop and compare.
module tb_grf_scoreboard;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    localparam int M_D0 = 1;
    localparam int M_B0 = 2;
    localparam int M_D1 = 4;
    localparam int M_B1 = 8;
    localparam int M_CNT = 16;
    localparam int M_TV = 32;
    localparam int M_TR = 64;

    logic               clk;
    logic               reset;
    logic [NR*AW-1:0]   rd_addr;
    logic [NR*DW-1:0]   rd_data;
    logic [NR-1:0]      rd_busy;
    logic               we;
    logic [AW-1:0]      wa;
    logic [DW-1:0]      wd;
    logic [31:0]        wpc;
    logic               iss_en;
    logic [AW-1:0]      iss_addr;
    logic [AW:0]        busy_cnt;
    logic               trace_valid;
    logic [31:0]        trace_pc;
    logic [AW-1:0]      trace_addr;
    logic [DW-1:0]      trace_data;

    grf_scoreboard #(.DW(DW), .AW(AW), .NR(NR)) dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_busy(rd_busy), .we(we), .wa(wa), .wd(wd), .wpc(wpc),
        .iss_en(iss_en), .iss_addr(iss_addr), .busy_cnt(busy_cnt),
        .trace_valid(trace_valid), .trace_pc(trace_pc),
        .trace_addr(trace_addr), .trace_data(trace_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        int           mask;
        logic [31:0]  d0;
        logic         b0;
        logic [31:0]  d1;
        logic         b1;
        logic [5:0]   cnt;
        logic         tv;
        logic [31:0]  tpc;
        logic [4:0]   ta;
        logic [31:0]  td;
    } exp_t;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  addr;
        logic [31:0] data;
    } trc_t;

    exp_t exp_q[$];
    trc_t trc_q[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic drive(input bit r, input bit w, input int wa_, input logic [31:0] wd_,
                         input logic [31:0] pc_, input bit ie, input int ia,
                         input int a0, input int a1);
        @(posedge clk);
        #1;
        reset    = r;
        we       = w;
        wa       = AW'(wa_);
        wd       = wd_;
        wpc      = pc_;
        iss_en   = ie;
        iss_addr = AW'(ia);
        rd_addr  = {AW'(a1), AW'(a0)};
    endtask

    task automatic idle(input int a0, input int a1);
        drive(0, 0, 0, 32'h0, 32'h0, 0, 0, a0, a1);
    endtask

    task automatic expect_cyc(input string name, input int mask,
                              input logic [31:0] d0, input logic b0,
                              input logic [31:0] d1, input logic b1,
                              input logic [5:0] cnt, input logic tv,
                              input logic [31:0] tpc, input logic [4:0] ta,
                              input logic [31:0] td);
        exp_t e;
        e.name = name; e.mask = mask; e.d0 = d0; e.b0 = b0; e.d1 = d1; e.b1 = b1;
        e.cnt = cnt; e.tv = tv; e.tpc = tpc; e.ta = ta; e.td = td;
        exp_q.push_back(e);
    endtask

    task automatic expect_trace(input logic [31:0] pc, input logic [4:0] addr, input logic [31:0] data);
        trc_t t;
        t.pc = pc; t.addr = addr; t.data = data;
        trc_q.push_back(t);
    endtask

    // Per-cycle output monitor
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if ((e.mask & M_D0) != 0)  chk({e.name, "_d0"}, 64'(rd_data[31:0]), 64'(e.d0));
            if ((e.mask & M_B0) != 0)  chk({e.name, "_b0"}, 64'(rd_busy[0]), 64'(e.b0));
            if ((e.mask & M_D1) != 0)  chk({e.name, "_d1"}, 64'(rd_data[63:32]), 64'(e.d1));
            if ((e.mask & M_B1) != 0)  chk({e.name, "_b1"}, 64'(rd_busy[1]), 64'(e.b1));
            if ((e.mask & M_CNT) != 0) chk({e.name, "_cnt"}, 64'(busy_cnt), 64'(e.cnt));
            if ((e.mask & M_TV) != 0)  chk({e.name, "_tv"}, 64'(trace_valid), 64'(e.tv));
            if ((e.mask & M_TR) != 0) begin
                chk({e.name, "_tpc"}, 64'(trace_pc), 64'(e.tpc));
                chk({e.name, "_ta"}, 64'(trace_addr), 64'(e.ta));
                chk({e.name, "_td"}, 64'(trace_data), 64'(e.td));
            end
        end
    end

    // Trace monitor
    always @(negedge clk) begin
        if (trace_valid === 1'b1) begin
            if (trc_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL trace_unexpected actual=%0h/%0h/%0h required=none",
                         trace_pc, trace_addr, trace_data);
            end else begin
                trc_t t;
                t = trc_q.pop_front();
                chk("trace_pc", 64'(trace_pc), 64'(t.pc));
                chk("trace_addr", 64'(trace_addr), 64'(t.addr));
                chk("trace_data", 64'(trace_data), 64'(t.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; we = 1'b0; wa = '0; wd = '0; wpc = '0;
        iss_en = 1'b0; iss_addr = '0; rd_addr = '0;

        // Reset state
        drive(1, 0, 0, 0, 0, 0, 0, 5, 0);
        expect_cyc("reset", M_D0|M_B0|M_D1|M_B1|M_CNT|M_TV|M_TR, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Committed write with bypass, then trace
        drive(0, 1, 5, 32'h1234_5678, 32'h3000, 0, 0, 5, 6);
        expect_cyc("byp5", M_D0|M_B0|M_D1, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_trace(32'h3000, 5, 32'h1234_5678);
        idle(5, 0);
        expect_cyc("rd5", M_D0|M_D1|M_TV|M_TR, 32'h1234_5678, 0, 0, 0, 0, 1, 32'h3000, 5, 32'h1234_5678);
        idle(5, 0);
        expect_cyc("trace_hold", M_TV|M_TR, 0, 0, 0, 0, 0, 0, 32'h3000, 5, 32'h1234_5678);

        // Write to register 0 is ignored
        drive(0, 1, 0, 32'hFFFF_FFFF, 32'h4000, 0, 0, 0, 5);
        expect_cyc("r0_same", M_D0|M_D1, 0, 0, 32'h1234_5678, 0, 0, 0, 0, 0, 0);
        idle(0, 0);
        expect_cyc("r0_next", M_D0|M_TV|M_TR, 0, 0, 0, 0, 0, 0, 32'h3000, 5, 32'h1234_5678);

        // Issue 3, 7, 3 then writeback 3
        drive(0, 0, 0, 0, 0, 1, 3, 3, 0);
        expect_cyc("iss3_pre", M_B0|M_CNT, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 7, 3, 7);
        expect_cyc("iss3", M_B0|M_B1|M_CNT, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 3, 3, 7);
        expect_cyc("iss7", M_B0|M_B1|M_CNT, 0, 1, 0, 1, 2, 0, 0, 0, 0);
        drive(0, 1, 3, 32'h33, 32'h3010, 0, 0, 3, 7);
        expect_cyc("iss3_again", M_D0|M_B0|M_B1|M_CNT, 32'h33, 0, 0, 1, 2, 0, 0, 0, 0);
        expect_trace(32'h3010, 3, 32'h33);
        idle(3, 7);
        expect_cyc("wb3", M_D0|M_B0|M_B1|M_CNT|M_TV, 32'h33, 0, 0, 1, 1, 1, 0, 0, 0);

        // Simultaneous issue and writeback to busy register 9
        drive(0, 0, 0, 0, 0, 1, 9, 9, 0);
        expect_cyc("iss9_pre", M_CNT, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        drive(0, 1, 9, 32'h99, 32'h3020, 1, 9, 9, 0);
        expect_cyc("iss_wb9", M_D0|M_B0|M_CNT, 32'h99, 0, 0, 0, 2, 0, 0, 0, 0);
        expect_trace(32'h3020, 9, 32'h99);
        idle(9, 0);
        expect_cyc("after9", M_D0|M_B0|M_CNT|M_TV|M_TR, 32'h99, 1, 0, 0, 2, 1, 32'h3020, 9, 32'h99);

        // Port 1 bypass of a busy register
        drive(0, 0, 0, 0, 0, 1, 4, 0, 4);
        expect_cyc("iss4_pre", M_CNT, 0, 0, 0, 0, 2, 0, 0, 0, 0);
        drive(0, 1, 4, 32'hAA, 32'h3030, 0, 0, 7, 4);
        expect_cyc("byp4", M_D1|M_B1|M_B0|M_CNT, 0, 1, 32'hAA, 0, 3, 0, 0, 0, 0);
        expect_trace(32'h3030, 4, 32'hAA);
        idle(4, 7);
        expect_cyc("wb4", M_D0|M_B0|M_B1|M_CNT|M_TV, 32'hAA, 0, 0, 1, 2, 1, 0, 0, 0);

        // Writeback to a non-busy register
        drive(0, 1, 5, 32'h55, 32'h3040, 0, 0, 5, 0);
        expect_cyc("wb_nb", M_CNT, 0, 0, 0, 0, 2, 0, 0, 0, 0);
        expect_trace(32'h3040, 5, 32'h55);
        idle(5, 0);
        expect_cyc("wb_nb_cnt", M_D0|M_CNT|M_TV, 32'h55, 0, 0, 0, 2, 1, 0, 0, 0);

        // Issue 1..4, then reset with a concurrent write and issue
        drive(0, 0, 0, 0, 0, 1, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 2, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 3, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 4, 0, 0);
        drive(1, 1, 2, 32'hBEEF, 32'h3050, 1, 6, 2, 6);
        expect_cyc("pre_rst", M_CNT, 0, 0, 0, 0, 6, 0, 0, 0, 0);
        idle(2, 6);
        expect_cyc("rst_dom", M_D0|M_B0|M_B1|M_CNT|M_TV|M_TR, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Scoreboard usable again after reset
        drive(0, 0, 0, 0, 0, 1, 7, 7, 0);
        expect_cyc("post_rst_pre", M_B0|M_CNT, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(7, 0);
        expect_cyc("post_rst", M_B0|M_CNT|M_TV, 0, 1, 0, 0, 1, 0, 0, 0, 0);

        idle(0, 0);
        idle(0, 0);
        @(negedge clk);
        #1;
        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        chk("trace_q_drained", 64'(trc_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
